// File: rtl/mem_loader.sv
// mem_loader: byte-stream host loader for the processor's external memory port.
// Decodes framed IRAM/DRAM load commands, writes 16-bit words through the
// external load port and finally launches the processor with a sticky start.
module mem_loader #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int BASE_ADDR = 1,
  parameter int WR_HOLD   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr_ext,
  output logic [DATA_W-1:0] Data_in_ins,
  output logic [DATA_W-1:0] Data_in_dram,
  output logic              iram_write_ext,
  output logic              dram_write_ext,
  output logic              start_2,
  output logic              start_3,
  output logic              start,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0] HDR_IRAM  = 8'hA1;
  localparam logic [7:0] HDR_DRAM  = 8'hD1;
  localparam logic [7:0] HDR_START = 8'h5A;

  // Largest word count that keeps every write address inside the memory.
  localparam logic [16:0] CNT_LIMIT = 17'((1 << ADDR_W) - BASE_ADDR);

  localparam int HOLD_W = $clog2(WR_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WR_HOLD);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_RUN
  } state_t;

  state_t            state_q, state_d;

  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dins_q, dins_d;
  logic [DATA_W-1:0] ddram_q, ddram_d;
  logic              we_i_q, we_i_d;
  logic              we_d_q, we_d_d;
  logic              mode_i_q, mode_i_d;
  logic              mode_d_q, mode_d_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic [15:0]       words_q, words_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        dat_hi_q, dat_hi_d;

  logic              accept;
  logic [15:0]       count_full;
  logic              hold_done;
  logic              last_word;
  logic [DATA_W-1:0] word_full;

  assign accept     = in_valid && in_ready_q;
  assign count_full = {cnt_hi_q, in_data};
  assign hold_done  = (hold_q == HOLD_LAST);
  assign last_word  = (words_q == count_q);
  assign word_full  = DATA_W'({dat_hi_q, in_data});

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_data == HDR_IRAM || in_data == HDR_DRAM) state_d = S_CNT_HI;
          else if (in_data == HDR_START)                  state_d = S_RUN;
        end
      end
      S_CNT_HI: if (accept) state_d = S_CNT_LO;
      S_CNT_LO: begin
        if (accept) begin
          if (count_full == 16'd0 || {1'b0, count_full} > CNT_LIMIT) state_d = S_IDLE;
          else                                                       state_d = S_DAT_HI;
        end
      end
      S_DAT_HI: if (accept) state_d = S_DAT_LO;
      S_DAT_LO: if (accept) state_d = S_WRITE;
      S_WRITE: begin
        if (hold_done) state_d = last_word ? S_IDLE : S_DAT_HI;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode: next values of every registered output and counter
  always_comb begin
    in_ready_d = 1'b0;
    addr_d     = addr_q;
    dins_d     = dins_q;
    ddram_d    = ddram_q;
    we_i_d     = 1'b0;
    we_d_d     = 1'b0;
    mode_i_d   = mode_i_q;
    mode_d_d   = mode_d_q;
    start_d    = start_q;
    err_d      = 1'b0;
    words_d    = words_q;
    hold_d     = hold_q;
    cnt_hi_d   = cnt_hi_q;
    count_d    = count_q;
    dat_hi_d   = dat_hi_q;

    case (state_d)
      S_IDLE, S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO: in_ready_d = 1'b1;
      default:                                        in_ready_d = 1'b0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_data == HDR_IRAM) begin
            mode_i_d = 1'b1;
            mode_d_d = 1'b0;
            addr_d   = ADDR_W'(BASE_ADDR);
            words_d  = 16'd0;
          end else if (in_data == HDR_DRAM) begin
            mode_i_d = 1'b0;
            mode_d_d = 1'b1;
            addr_d   = ADDR_W'(BASE_ADDR);
            words_d  = 16'd0;
          end else if (in_data == HDR_START) begin
            start_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CNT_HI: if (accept) cnt_hi_d = in_data;
      S_CNT_LO: begin
        if (accept) begin
          count_d = count_full;
          if (count_full == 16'd0) begin
            mode_i_d = 1'b0;
            mode_d_d = 1'b0;
          end else if ({1'b0, count_full} > CNT_LIMIT) begin
            mode_i_d = 1'b0;
            mode_d_d = 1'b0;
            err_d    = 1'b1;
          end
        end
      end
      S_DAT_HI: if (accept) dat_hi_d = in_data;
      S_DAT_LO: begin
        if (accept) begin
          words_d = words_q + 16'd1;
          hold_d  = '0;
          if (mode_i_q) dins_d  = word_full;
          else          ddram_d = word_full;
        end
      end
      S_WRITE: begin
        // One setup cycle with the enable low, then WR_HOLD cycles high.
        if (hold_done) begin
          addr_d = addr_q + 1'b1;
          if (last_word) begin
            mode_i_d = 1'b0;
            mode_d_d = 1'b0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
          we_i_d = mode_i_q;
          we_d_d = mode_d_q;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and frame counters, all cleared by reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      in_ready_q <= 1'b0;
      addr_q     <= ADDR_W'(BASE_ADDR);
      dins_q     <= '0;
      ddram_q    <= '0;
      we_i_q     <= 1'b0;
      we_d_q     <= 1'b0;
      mode_i_q   <= 1'b0;
      mode_d_q   <= 1'b0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
      hold_q     <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      addr_q     <= addr_d;
      dins_q     <= dins_d;
      ddram_q    <= ddram_d;
      we_i_q     <= we_i_d;
      we_d_q     <= we_d_d;
      mode_i_q   <= mode_i_d;
      mode_d_q   <= mode_d_d;
      start_q    <= start_d;
      err_q      <= err_d;
      words_q    <= words_d;
      hold_q     <= hold_d;
    end
  end

  // Byte capture registers; only read after being written within a frame
  always_ff @(posedge clock) begin
    cnt_hi_q <= cnt_hi_d;
    count_q  <= count_d;
    dat_hi_q <= dat_hi_d;
  end

  assign in_ready       = in_ready_q;
  assign addr_ext       = addr_q;
  assign Data_in_ins    = dins_q;
  assign Data_in_dram   = ddram_q;
  assign iram_write_ext = we_i_q;
  assign dram_write_ext = we_d_q;
  assign start_2        = mode_i_q;
  assign start_3        = mode_d_q;
  assign start          = start_q;
  assign err            = err_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_RUN);

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed self-checking bench for mem_loader.
module tb_mem_loader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] addr_ext;
  logic [15:0] Data_in_ins, Data_in_dram;
  logic       iram_write_ext, dram_write_ext;
  logic       start_2, start_3, start, busy, err;

  mem_loader #(.ADDR_W(9), .DATA_W(16), .BASE_ADDR(1), .WR_HOLD(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .addr_ext(addr_ext), .Data_in_ins(Data_in_ins),
    .Data_in_dram(Data_in_dram), .iram_write_ext(iram_write_ext),
    .dram_write_ext(dram_write_ext), .start_2(start_2), .start_3(start_3),
    .start(start), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: one record per contiguous enable pulse
  int q_mem[$], q_addr[$], q_data[$], q_len[$];
  int run = 0;
  int cur_mem, cur_addr, cur_data;
  int err_cnt = 0;
  logic err_prev = 1'b0;

  always @(negedge clock) begin
    if (iram_write_ext || dram_write_ext) begin
      chk("we_excl", {31'd0, iram_write_ext && dram_write_ext}, 0);
      chk("mode_with_we", {31'd0, iram_write_ext ? start_2 : start_3}, 1);
      if (run == 0) begin
        cur_mem  = dram_write_ext ? 1 : 0;
        cur_addr = int'(addr_ext);
        cur_data = dram_write_ext ? int'(Data_in_dram) : int'(Data_in_ins);
      end else begin
        chk("wr_stable", {7'd0, addr_ext, dram_write_ext ? Data_in_dram : Data_in_ins},
            {7'd0, cur_addr[8:0], cur_data[15:0]});
      end
      run++;
    end else if (run > 0) begin
      q_mem.push_back(cur_mem);
      q_addr.push_back(cur_addr);
      q_data.push_back(cur_data);
      q_len.push_back(run);
      run = 0;
    end
    if (start_2 || start_3) chk("modes_excl", {31'd0, start_2 && start_3}, 0);
    if (err) begin
      chk("err_one_cycle", {31'd0, err_prev}, 0);
      err_cnt++;
    end
    err_prev = err;
  end

  task automatic clr_wr();
    q_mem.delete(); q_addr.delete(); q_data.delete(); q_len.delete();
  endtask

  task automatic chk_wr(input int idx, input int mem, input int addr, input int data, input int len);
    if (idx < q_addr.size()) begin
      chk($sformatf("wr%0d_mem", idx),  q_mem[idx],  mem);
      chk($sformatf("wr%0d_addr", idx), q_addr[idx], addr);
      chk($sformatf("wr%0d_data", idx), q_data[idx], data);
      chk($sformatf("wr%0d_len", idx),  q_len[idx],  len);
    end else begin
      chk($sformatf("wr%0d_present", idx), 0, 1);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one byte after an optional stall; returns 1 ns after the accepting edge
  task automatic send(input logic [7:0] b, input int max_stall);
    int s;
    int n;
    s = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
    repeat (s) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick(1);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) chk("send_timeout", 0, 1);
    tick(1);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick(3);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_addr", {23'd0, addr_ext}, 1);
    chk("rst_data", {Data_in_ins, Data_in_dram}, 0);
    chk("rst_ctrl", {24'd0, iram_write_ext, dram_write_ext, start_2, start_3, start, busy, err, 1'b0}, 0);
    reset_n = 1'b1;
    tick(1);
    chk("rel_in_ready", {31'd0, in_ready}, 1);

    // IRAM frame A1 0002 1234 ABCD with exact write timing on word 1
    clr_wr();
    send(8'hA1, 0);
    chk("t1_start2", {31'd0, start_2}, 1);
    chk("t1_addr0", {23'd0, addr_ext}, 1);
    chk("t1_busy", {31'd0, busy}, 1);
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    chk("t1_k_ready", {31'd0, in_ready}, 0);
    chk("t1_k_data", {16'd0, Data_in_ins}, 32'h1234);
    chk("t1_k_we", {31'd0, iram_write_ext}, 0);
    tick(1);
    chk("t1_k1_we", {31'd0, iram_write_ext}, 1);
    tick(3);
    chk("t1_k4_we", {31'd0, iram_write_ext}, 1);
    chk("t1_k4_addr", {23'd0, addr_ext}, 1);
    tick(1);
    chk("t1_k5_we", {31'd0, iram_write_ext}, 0);
    chk("t1_k5_addr", {23'd0, addr_ext}, 2);
    chk("t1_k5_ready", {31'd0, in_ready}, 1);
    send(8'hAB, 0);
    send(8'hCD, 0);
    tick(8);
    chk("t1_nwr", q_addr.size(), 2);
    chk_wr(0, 0, 1, 32'h1234, 4);
    chk_wr(1, 0, 2, 32'hABCD, 4);
    chk("t1_end_mode", {30'd0, start_2, start_3}, 0);
    chk("t1_end_busy", {31'd0, busy}, 0);
    chk("t1_end_addr", {23'd0, addr_ext}, 3);
    chk("t1_dram_data", {16'd0, Data_in_dram}, 0);

    // DRAM frame D1 0003 0001 0002 0003 with random valid stalls
    clr_wr();
    send(8'hD1, 3); send(8'h00, 3); send(8'h03, 3);
    send(8'h00, 3); send(8'h01, 3);
    send(8'h00, 3); send(8'h02, 3);
    send(8'h00, 3); send(8'h03, 3);
    tick(8);
    chk("t2_nwr", q_addr.size(), 3);
    chk_wr(0, 1, 1, 1, 4);
    chk_wr(1, 1, 2, 2, 4);
    chk_wr(2, 1, 3, 3, 4);
    chk("t2_ins_kept", {16'd0, Data_in_ins}, 32'hABCD);
    chk("t2_end_mode", {30'd0, start_2, start_3}, 0);

    // Bad header, zero-count frame, oversize frame
    clr_wr();
    err_cnt = 0;
    send(8'h77, 0);
    chk("t3_bad_err", {31'd0, err}, 1);
    tick(1);
    chk("t3_bad_err_drop", {31'd0, err}, 0);
    chk("t3_bad_idle", {30'd0, in_ready, busy}, 32'd2);
    send(8'hA1, 0); send(8'h00, 0); send(8'h00, 0);
    chk("t3_zero_mode", {31'd0, start_2}, 0);
    chk("t3_zero_busy", {31'd0, busy}, 0);
    chk("t3_zero_err", {31'd0, err}, 0);
    send(8'hD1, 0); send(8'h02, 0); send(8'h00, 0);
    chk("t3_big_err", {31'd0, err}, 1);
    chk("t3_big_mode", {31'd0, start_3}, 0);
    chk("t3_big_busy", {31'd0, busy}, 0);
    tick(6);
    chk("t3_err_cnt", err_cnt, 2);
    chk("t3_nwr", q_addr.size(), 0);

    // Reset during the second cycle of word 2's write, then reload
    clr_wr();
    send(8'hA1, 0); send(8'h00, 0); send(8'h02, 0);
    send(8'h12, 0); send(8'h34, 0);
    send(8'hAB, 0); send(8'hCD, 0);
    tick(2);
    chk("t4_we_before", {31'd0, iram_write_ext}, 1);
    reset_n = 1'b0;
    tick(1);
    chk("t4_rst_we", {31'd0, iram_write_ext}, 0);
    chk("t4_rst_mode", {30'd0, start_2, start}, 0);
    chk("t4_rst_addr", {23'd0, addr_ext}, 1);
    chk("t4_rst_ready", {31'd0, in_ready}, 0);
    chk("t4_rst_data", {16'd0, Data_in_ins}, 0);
    reset_n = 1'b1;
    tick(1);
    chk("t4_rel_ready", {31'd0, in_ready}, 1);
    chk("t4_nwr", q_addr.size(), 2);
    chk_wr(1, 0, 2, 32'hABCD, 2);
    clr_wr();
    send(8'hA1, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'hBE, 0); send(8'hEF, 0);
    tick(8);
    chk("t4_re_nwr", q_addr.size(), 1);
    chk_wr(0, 0, 1, 32'hBEEF, 4);

    // Start command, then ignored traffic
    clr_wr();
    send(8'h5A, 0);
    chk("t5_start", {31'd0, start}, 1);
    chk("t5_ready", {31'd0, in_ready}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_mode", {30'd0, start_2, start_3}, 0);
    in_valid = 1'b1;
    in_data  = 8'hA1;
    tick(10);
    in_valid = 1'b0;
    chk("t5_hold_start", {31'd0, start}, 1);
    chk("t5_hold_ready", {31'd0, in_ready}, 0);
    chk("t5_hold_mode", {30'd0, start_2, start_3}, 0);
    chk("t5_nwr", q_addr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
